// File: rtl/rv32_pc_v3.sv
// Fetch program counter with a direct-mapped BTB and 2-bit counters.
// Ports: clk/rst, enable/stall/busy, ex_* resolution in; pc, prediction,
//   link_addr, flush/misalign pulses and halt out.
module rv32_pc_v3 #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 'h0,
  parameter logic [XLEN-1:0] TRAP_VECTOR = 'h100,
  parameter int BTB_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            stall,
  input  logic            busy,
  input  logic            ex_valid,
  input  logic            ex_is_cti,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic [XLEN-1:0] pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  output logic [XLEN-1:0] link_addr,
  output logic            flush,
  output logic            misalign,
  output logic            halt
);

  localparam int IDX = $clog2(BTB_DEPTH);
  localparam int TW = XLEN - IDX - 2;

  logic [BTB_DEPTH-1:0] b_valid;
  logic [TW-1:0]        b_tag [BTB_DEPTH];
  logic [XLEN-3:0]      b_tgt [BTB_DEPTH];
  logic [1:0]           b_ctr [BTB_DEPTH];

  logic [IDX-1:0]  f_idx;
  logic            f_hit;
  logic [XLEN-1:0] pc_plus4;

  logic [IDX-1:0]  e_idx;
  logic [TW-1:0]   e_tag;
  logic            e_hit;
  logic [1:0]      e_ctr;
  logic [1:0]      e_ctr_nx;

  logic            resolve;
  logic            mis;
  logic            mispred;
  logic            advance;
  logic            tgt_ok;
  logic [XLEN-1:0] fix_pc;
  logic [XLEN-1:0] pc_nx;

  // Fetch-side lookup, same cycle as pc.
  assign f_idx    = pc[IDX+1:2];
  assign f_hit    = b_valid[f_idx] &&
                    (b_tag[f_idx] == pc[XLEN-1:IDX+2]);
  assign pc_plus4 = pc + XLEN'(4);

  assign pred_taken  = f_hit && b_ctr[f_idx][1];
  assign pred_target = pred_taken ?
                       {b_tgt[f_idx], 2'b00} : pc_plus4;

  assign link_addr = ex_pc + XLEN'(4);
  assign halt      = ~enable;

  // Execute-side resolution.
  assign e_idx = ex_pc[IDX+1:2];
  assign e_tag = ex_pc[XLEN-1:IDX+2];
  assign e_hit = b_valid[e_idx] && (b_tag[e_idx] == e_tag);
  assign e_ctr = b_ctr[e_idx];

  assign resolve = ex_valid && ex_is_cti;
  assign mis     = resolve && ex_taken &&
                   (ex_target[1:0] != 2'b00);
  assign tgt_ok  = ex_taken && !mis;

  // A non-CTI carrying a taken prediction came from an aliased entry.
  always_comb begin
    mispred = 1'b0;
    if (ex_valid) begin
      if (ex_is_cti)
        mispred = (ex_taken != ex_pred_taken) ||
                  (ex_taken && ex_target != ex_pred_target);
      else
        mispred = ex_pred_taken;
    end
  end

  assign fix_pc  = (ex_is_cti && ex_taken) ? ex_target : link_addr;
  assign advance = enable && !stall && !busy;

  always_comb begin
    e_ctr_nx = e_ctr;
    if (ex_taken)
      e_ctr_nx = (e_ctr == 2'b11) ? 2'b11 : e_ctr + 2'd1;
    else
      e_ctr_nx = (e_ctr == 2'b00) ? 2'b00 : e_ctr - 2'd1;
  end

  // Redirects override enable/stall/busy.
  always_comb begin
    pc_nx = pc;
    unique case (1'b1)
      mis:                      pc_nx = TRAP_VECTOR;
      mispred && !mis:          pc_nx = fix_pc;
      advance && !mis
        && !mispred:            pc_nx = pred_target;
      default:                  pc_nx = pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_VECTOR;
      flush    <= 1'b0;
      misalign <= 1'b0;
    end else begin
      pc       <= pc_nx;
      flush    <= mis || mispred;
      misalign <= mis;
    end
  end

  // Lookups this cycle see pre-write contents (no bypass).
  always_ff @(posedge clk) begin
    if (rst) begin
      b_valid <= '0;
    end else if (resolve) begin
      if (e_hit) begin
        b_ctr[e_idx] <= e_ctr_nx;
        if (tgt_ok)
          b_tgt[e_idx] <= ex_target[XLEN-1:2];
      end else if (tgt_ok) begin
        b_valid[e_idx] <= 1'b1;
        b_tag[e_idx]   <= e_tag;
        b_tgt[e_idx]   <= ex_target[XLEN-1:2];
        b_ctr[e_idx]   <= 2'b10;
      end
    end else if (ex_valid && ex_pred_taken && e_hit) begin
      b_valid[e_idx] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rv32_pc_v3.sv
// Randomised and directed bench for rv32_pc_v3 against a
// behavioural model of the fetch PC and its BTB.
module tb_rv32_pc_v3;

  localparam int D = 8;

  logic        clk = 1'b0;
  logic        rst, enable, stall, busy;
  logic        ex_valid, ex_is_cti, ex_taken, ex_pred_taken;
  logic [31:0] ex_pc, ex_target, ex_pred_target;
  logic [31:0] pc, pred_target, link_addr;
  logic        pred_taken, flush, misalign, halt;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: each slot remembers the full branch pc.
  logic [31:0] m_pc;
  bit          m_fl, m_mi;
  bit          bv [D];
  logic [31:0] bpc [D];
  logic [31:0] btg [D];
  int          bct [D];

  rv32_pc_v3 dut (
    .clk(clk), .rst(rst), .enable(enable),
    .stall(stall), .busy(busy),
    .ex_valid(ex_valid), .ex_is_cti(ex_is_cti),
    .ex_taken(ex_taken), .ex_pc(ex_pc),
    .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target),
    .pc(pc), .pred_taken(pred_taken),
    .pred_target(pred_target), .link_addr(link_addr),
    .flush(flush), .misalign(misalign), .halt(halt)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic bit m_hit(logic [31:0] a);
    int i = int'((a >> 2) % D);
    return bv[i] && ((bpc[i] >> 2) == (a >> 2));
  endfunction

  function automatic bit m_ptk();
    int i = int'((m_pc >> 2) % D);
    return m_hit(m_pc) && bct[i] >= 2;
  endfunction

  function automatic logic [31:0] m_ptg();
    int i = int'((m_pc >> 2) % D);
    return m_ptk() ? btg[i] : m_pc + 32'd4;
  endfunction

  task automatic m_reset();
    m_pc = 32'h0;
    m_fl = 0;
    m_mi = 0;
    foreach (bv[k]) bv[k] = 0;
  endtask

  task automatic m_step();
    bit cti = ex_valid && ex_is_cti;
    bit mi = cti && ex_taken && (ex_target[1:0] != 2'b00);
    bit mp = 0;
    bit hit = m_hit(ex_pc);
    int i = int'((ex_pc >> 2) % D);
    logic [31:0] seq = m_ptg();
    if (ex_valid && ex_is_cti)
      mp = (ex_taken != ex_pred_taken) ||
           (ex_taken && ex_target != ex_pred_target);
    else if (ex_valid)
      mp = ex_pred_taken;
    if (rst) begin
      m_reset();
      return;
    end
    m_fl = mi || mp;
    m_mi = mi;
    if (mi) m_pc = 32'h100;
    else if (mp)
      m_pc = (ex_is_cti && ex_taken) ? ex_target
                                     : ex_pc + 32'd4;
    else if (enable && !stall && !busy) m_pc = seq;
    if (cti) begin
      if (hit) begin
        bct[i] = ex_taken ? (bct[i] < 3 ? bct[i] + 1 : 3)
                          : (bct[i] > 0 ? bct[i] - 1 : 0);
        if (ex_taken && !mi) btg[i] = ex_target;
      end else if (ex_taken && !mi) begin
        bv[i] = 1;
        bpc[i] = ex_pc;
        btg[i] = ex_target;
        bct[i] = 2;
      end
    end else if (ex_valid && ex_pred_taken && hit) begin
      bv[i] = 0;
    end
  endtask

  // One clock: comb outputs checked mid-low-phase, registered after edge.
  task automatic cyc();
    #1;
    chk("pred_taken", 32'(pred_taken), 32'(m_ptk()));
    chk("pred_target", pred_target, m_ptg());
    chk("link_addr", link_addr, ex_pc + 32'd4);
    chk("halt", 32'(halt), 32'(!enable));
    m_step();
    @(posedge clk);
    #1;
    chk("pc", pc, m_pc);
    chk("flush", 32'(flush), 32'(m_fl));
    chk("misalign", 32'(misalign), 32'(m_mi));
    @(negedge clk);
  endtask

  task automatic ex_clr();
    ex_valid = 0; ex_is_cti = 0; ex_taken = 0;
    ex_pc = 0; ex_target = 0;
    ex_pred_taken = 0; ex_pred_target = 0;
  endtask

  task automatic ex_go(logic t, logic [31:0] p,
                       logic [31:0] tg, logic pt,
                       logic [31:0] ptg);
    ex_valid = 1; ex_is_cti = 1; ex_taken = t;
    ex_pc = p; ex_target = tg;
    ex_pred_taken = pt; ex_pred_target = ptg;
    cyc();
    ex_clr();
  endtask

  // Unpredicted taken jump from 0x8 steers fetch anywhere.
  task automatic go_to(logic [31:0] a);
    ex_go(1, 32'h8, a, 0, 0);
  endtask

  initial begin
    rst = 1; enable = 0; stall = 0; busy = 0;
    ex_clr();
    repeat (3) @(posedge clk);
    @(negedge clk);
    m_reset();
    chk("rst_pc", pc, 32'h0);
    chk("rst_flush", 32'(flush), 32'h0);
    chk("rst_mis", 32'(misalign), 32'h0);
    chk("rst_pt", 32'(pred_taken), 32'h0);
    rst = 0;
    enable = 1;

    for (int k = 1; k <= 4; k++) begin
      cyc();
      chk("seq_pc", pc, 32'(k * 4));
    end

    ex_go(1, 32'h10, 32'h40, 0, 0);
    chk("bt_pc", pc, 32'h40);
    chk("bt_flush", 32'(flush), 32'h1);
    cyc();
    chk("bt_flush_off", 32'(flush), 32'h0);
    go_to(32'h10);
    chk("bt_pred", 32'(pred_taken), 32'h1);
    chk("bt_tgt", pred_target, 32'h40);

    ex_go(0, 32'h10, 32'h0, 1, 32'h40);
    chk("nt1_pc", pc, 32'h14);
    chk("nt1_flush", 32'(flush), 32'h1);
    ex_go(0, 32'h10, 32'h0, 1, 32'h40);
    chk("nt2_pc", pc, 32'h14);
    go_to(32'h10);
    chk("nt_pred", 32'(pred_taken), 32'h0);
    chk("nt_tgt", pred_target, 32'h14);

    ex_go(1, 32'h30, 32'h102, 0, 0);
    chk("ma_pc", pc, 32'h100);
    chk("ma_mis", 32'(misalign), 32'h1);
    chk("ma_flush", 32'(flush), 32'h1);
    go_to(32'h30);
    chk("ma_noalloc", 32'(pred_taken), 32'h0);

    go_to(32'h20);
    stall = 1;
    cyc();
    chk("st_hold", pc, 32'h20);
    ex_go(1, 32'h50, 32'h80, 0, 0);
    chk("st_redir", pc, 32'h80);
    cyc();
    chk("st_hold2", pc, 32'h80);
    stall = 0;
    cyc();

    go_to(32'hFFFF_FFFC);
    cyc();
    chk("wrap_pc", pc, 32'h0);

    rst = 1;
    ex_go(1, 32'h60, 32'h90, 0, 0);
    rst = 0;
    chk("rr_pc", pc, 32'h0);
    chk("rr_flush", 32'(flush), 32'h0);
    go_to(32'h10);
    chk("rr_btb", 32'(pred_taken), 32'h0);

    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      enable = ($urandom_range(0, 7) != 0);
      stall = ($urandom_range(0, 5) == 0);
      busy = ($urandom_range(0, 5) == 0);
      ex_valid = ($urandom_range(0, 9) < 4);
      ex_is_cti = ($urandom_range(0, 19) < 17);
      ex_taken = 1'($urandom_range(0, 1));
      ex_pc = 32'($urandom_range(0, 63)) << 2;
      if ($urandom_range(0, 7) == 0) ex_pc |= 32'h1000;
      ex_target = 32'($urandom_range(0, 63)) << 2;
      if ($urandom_range(0, 15) == 0)
        ex_target += 32'($urandom_range(1, 3));
      ex_pred_taken = 1'($urandom_range(0, 1));
      ex_pred_target = ($urandom_range(0, 1) == 1) ? ex_target
                     : 32'($urandom_range(0, 63)) << 2;
      cyc();
    end
    rst = 0;
    ex_clr();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
